// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N channels, paced by a frame timer.
// Optional per-grant header byte {4'hA, id} is enabled by defining UART_TXARB_HEADER_EN.
module uart_tx_arbiter #(
    parameter int CLOCK = 50000000,
    parameter int BAUD  = 9600,
    parameter int N     = 4,
    parameter int DATA  = 8,
    parameter int GAP   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*DATA-1:0]      data,
    output logic [N-1:0]           ack,
    output logic                   uart_new_data,
    output logic [DATA-1:0]        uart_data,
    output logic                   busy,
    output logic [$clog2(N)-1:0]   grant_id
);
    localparam int FRAME = (CLOCK / BAUD) * (DATA + 2) + GAP;
    localparam int CW    = $clog2(FRAME + 1);
    localparam int GW    = $clog2(N);

`ifdef UART_TXARB_HEADER_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_HWAIT, S_SEND, S_DWAIT, S_ACK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_DWAIT, S_ACK} state_t;
`endif

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [GW-1:0]   r_last;
    logic [GW-1:0]   r_grant;
    logic [N-1:0]    r_ack;
    logic            r_new_data;
    logic [DATA-1:0] r_uart_data;
    logic            w_found;
    logic [GW-1:0]   w_winner;
    logic [DATA-1:0] w_sel_data;

    // Search begins one past the last acknowledged channel, so it has lowest priority next.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 1; i <= N; i++) begin
            if (!w_found && req[(int'(r_last) + i) % N]) begin
                w_found  = 1'b1;
                w_winner = GW'((int'(r_last) + i) % N);
            end
        end
    end

    assign w_sel_data = data[int'(w_winner)*DATA +: DATA];

`ifdef UART_TXARB_HEADER_EN
    logic [DATA-1:0] r_hold;
    logic [3:0]      w_hdr_id;
    assign w_hdr_id = 4'(w_winner);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last      <= GW'(N - 1);
            r_grant     <= '0;
            r_ack       <= '0;
            r_new_data  <= 1'b0;
            r_uart_data <= '0;
`ifdef UART_TXARB_HEADER_EN
            r_hold      <= '0;
`endif
        end else begin
            r_new_data <= 1'b0;
            r_ack      <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_winner;
                        r_new_data <= 1'b1;
`ifdef UART_TXARB_HEADER_EN
                        r_hold      <= w_sel_data;
                        r_uart_data <= DATA'({4'hA, w_hdr_id});
                        r_state     <= S_HDR;
`else
                        r_uart_data <= w_sel_data;
                        r_state     <= S_SEND;
`endif
                    end
                end
`ifdef UART_TXARB_HEADER_EN
                S_HDR: begin
                    r_cnt   <= CW'(FRAME - 1);
                    r_state <= S_HWAIT;
                end
                S_HWAIT: begin
                    if (r_cnt == '0) begin
                        r_new_data  <= 1'b1;
                        r_uart_data <= r_hold;
                        r_state     <= S_SEND;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
`endif
                S_SEND: begin
                    r_cnt   <= CW'(FRAME - 1);
                    r_state <= S_DWAIT;
                end
                S_DWAIT: begin
                    if (r_cnt == '0) begin
                        r_ack   <= N'(1) << r_grant;
                        r_state <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_ACK: begin
                    r_last  <= r_grant;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack           = r_ack;
    assign uart_new_data = r_new_data;
    assign uart_data     = r_uart_data;
    assign busy          = (r_state != S_IDLE);
    assign grant_id      = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of single grants, multi-grant ordering, withdrawal, mid-frame reset.
module tb_uart_tx_arbiter;
  localparam int CLOCK = 1000;
  localparam int BAUD  = 100;
  localparam int N     = 4;
  localparam int DATA  = 8;
  localparam int GAP   = 4;
  localparam int FRAME = (CLOCK / BAUD) * (DATA + 2) + GAP;
`ifdef UART_TXARB_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif
  localparam int LAT_ACK = HDR ? 2 * FRAME + 3 : FRAME + 2;
  localparam int STEP    = HDR ? 2 : 1;
  localparam int SPACING = HDR ? 2 * FRAME + 4 : FRAME + 3;

  typedef struct {
    int             ch;
    logic [7:0]     b;
    logic [N-1:0]   ack;
    logic [7:0]     hdr;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*DATA-1:0] data = '0;
  logic [N-1:0]      ack;
  logic              uart_new_data;
  logic [DATA-1:0]   uart_data;
  logic              busy;
  logic [1:0]        grant_id;

  uart_tx_arbiter #(.CLOCK(CLOCK), .BAUD(BAUD), .N(N), .DATA(DATA), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack),
    .uart_new_data(uart_new_data), .uart_data(uart_data),
    .busy(busy), .grant_id(grant_id)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0]   exp_q[$];
  logic [N-1:0] ack_q[$];
  int           pt_q[$];
  logic         prev_nd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_grant(input int ch, input logic [7:0] b, input bit with_ack);
    if (HDR) exp_q.push_back({4'hA, 4'(ch)});
    exp_q.push_back(b);
    if (with_ack) ack_q.push_back(N'(1) << ch);
  endtask

  task automatic do_reset(input logic [N-1:0] r, input logic [N*DATA-1:0] d);
    @(negedge clk);
    rst = 1'b0;
    req = r;
    data = d;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (uart_new_data) begin
      chk("nd_back_to_back", prev_nd, 0);
      pt_q.push_back(cyc);
      chk("pulse_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("uart_data", uart_data, exp_q.pop_front());
    end
    prev_nd = uart_new_data;
    if (ack != '0) begin
      chk("ack_onehot", $onehot(ack), 1);
      chk("ack_expected", ack_q.size() > 0, 1);
      if (ack_q.size() > 0) chk("ack_value", ack, ack_q.pop_front());
    end
  end

  // driver: one isolated request, timing measured from the sampling IDLE cycle
  task automatic run_single(input vec_t v);
    int k;
    int t_p;
    int t_a;
    int busy_bad;
    int gid_bad;
    t_p = -1; t_a = -1; busy_bad = 0; gid_bad = 0;
    data[v.ch*DATA +: DATA] = v.b;
    req[v.ch] = 1'b1;
    if (HDR) exp_q.push_back(v.hdr);
    exp_q.push_back(v.b);
    ack_q.push_back(v.ack);
    k = cyc;
    for (int t = 0; t < LAT_ACK + 20; t++) begin
      @(negedge clk);
      if (uart_new_data && t_p < 0) t_p = cyc - k;
      if (!busy) busy_bad++;
      if (grant_id != 2'(v.ch)) gid_bad++;
      if (ack != '0) begin
        t_a = cyc - k;
        req[v.ch] = 1'b0;
        break;
      end
    end
    chk("first_pulse_latency", t_p, 1);
    chk("ack_latency", t_a, LAT_ACK);
    chk("busy_held", busy_bad, 0);
    chk("grant_id_held", gid_bad, 0);
    @(negedge clk);
    chk("busy_fall", busy, 0);
  endtask

  task automatic wait_acks(input int n);
    int got;
    got = 0;
    for (int t = 0; t < n * (2 * FRAME + 10) && got < n; t++) begin
      @(negedge clk);
      if (ack != '0) begin
        got++;
        if (got == n) req = '0;
      end
    end
    chk("acks_seen", got, n);
    repeat (2) @(negedge clk);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{1, 8'h5C, 4'b0010, 8'hA1};
    vecs[1] = '{0, 8'h00, 4'b0001, 8'hA0};
    vecs[2] = '{3, 8'hFF, 4'b1000, 8'hA3};
    vecs[3] = '{2, 8'(($urandom_range(1, 254))), 4'b0100, 8'hA2};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_new_data", uart_new_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_uart_data", uart_data, 0);
    rst = 1'b1;
    @(negedge clk);

    // table of single requests
    for (int i = 0; i < 4; i++) run_single(vecs[i]);

    // all four requesting from reset: order 0,1,2,3,0
    do_reset(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});
    pt_q.delete();
    push_grant(0, 8'h11, 1);
    push_grant(1, 8'h22, 1);
    push_grant(2, 8'h33, 1);
    push_grant(3, 8'h44, 1);
    push_grant(0, 8'h11, 1);
    wait_acks(5);
    chk("rr_pulse_count", pt_q.size(), 5 * STEP);
    for (int i = STEP; i < pt_q.size(); i += STEP)
      chk("pulse_spacing", pt_q[i] - pt_q[i-STEP], SPACING);

    // fairness: channels 0 and 2 alternate
    do_reset(4'b0101, {8'h00, 8'hC2, 8'h00, 8'hC0});
    push_grant(0, 8'hC0, 1);
    push_grant(2, 8'hC2, 1);
    push_grant(0, 8'hC0, 1);
    push_grant(2, 8'hC2, 1);
    wait_acks(4);

    // request withdrawn mid-frame
    do_reset(4'b0000, '0);
    @(negedge clk);
    pt_q.delete();
    data[3*DATA +: DATA] = 8'h3C;
    req[3] = 1'b1;
    push_grant(3, 8'h3C, 1);
    for (int t = 0; t < 5 && pt_q.size() == 0; t++) @(negedge clk);
    chk("withdraw_pulse_seen", pt_q.size() > 0, 1);
    repeat (10) @(negedge clk);
    req[3] = 1'b0;
    wait_acks(1);
    begin
      int n0;
      n0 = pt_q.size();
      repeat (2 * FRAME + 10) @(negedge clk);
      chk("no_regrant", pt_q.size(), n0);
      chk("withdraw_idle", busy, 0);
    end

    // reset during DWAIT, then a fresh grant to channel 2
    data[2*DATA +: DATA] = 8'h77;
    req[2] = 1'b1;
    push_grant(2, 8'h77, 0);
    for (int t = 0; t < LAT_ACK && exp_q.size() != 0; t++) @(negedge clk);
    chk("pre_reset_bytes_sent", exp_q.size(), 0);
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ack", ack, 0);
    chk("midrst_new_data", uart_new_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_grant_id", grant_id, 0);
    chk("midrst_uart_data", uart_data, 0);
    rst = 1'b1;
    run_single('{2, 8'h77, 4'b0100, 8'hA2});

    chk("exp_q_drained", exp_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmitter among N logger channels. Each channel presents a byte with a level request; the arbiter grants one channel at a time, drives the UART's `new_data`/`data_in` inputs, and paces bytes with an internal frame timer because the UART has no busy output. Each transfer ends with a one-cycle `ack` to the granted channel. The block sits between the sensor-channel logic and `uart`.

## Interface
- `CLOCK`, 50000000: system clock frequency in Hz.
- `BAUD`, 9600: UART baud rate; must match the `uart` instance.
- `N`, 4: number of requesters, 2..16.
- `DATA`, 8: byte width; must be 8 when `UART_TXARB_HEADER_EN` is defined.
- `GAP`, 16: extra idle cycles appended to every frame; must be ≥ 4.
- `clk`  in  1  system clock.
- `rst`  in  1  reset: synchronous, active-low.
- `req`  in  N  per-channel level request; held until that channel's `ack`.
- `data`  in  N*DATA  channel i byte at `[i*DATA +: DATA]`.
- `ack`  out  N  one-hot, single-cycle pulse when channel's byte is fully sent.
- `uart_new_data`  out  1  one-cycle start pulse to `uart.new_data`.
- `uart_data`  out  DATA  byte to `uart.data_in`; stable throughout the frame.
- `busy`  out  1  high whenever state ≠ IDLE.
- `grant_id`  out  $clog2(N)  index of granted channel; valid while `busy`.

## Operation
- FRAME = (CLOCK/BAUD)*(DATA+2) + GAP cycles, computed as a localparam. The frame counter is $clog2(FRAME+1) bits wide.
- States:
  - IDLE: `busy=0`. If any `req` bit is set, select the winner, latch `data[winner]` into a hold register, and latch `grant_id`. Go to HDR if the header is enabled, else to SEND.
  - HDR: one cycle. `uart_new_data=1`, `uart_data` = header byte. Load the counter with FRAME-1. Go to HWAIT.
  - HWAIT: decrement the counter. When it reaches 0, go to SEND.
  - SEND: one cycle. `uart_new_data=1`, `uart_data` = held byte. Load the counter with FRAME-1. Go to DWAIT.
  - DWAIT: decrement the counter. When it reaches 0, go to ACK.
  - ACK: one cycle. `ack[grant_id]=1`. Set `last` to `grant_id`. Go to IDLE.
- Round-robin winner: search starts at (`last`+1) mod N, wrapping. Reset value of `last` is N-1, so channel 0 has first priority.
- Data is sampled only in IDLE. Later changes to `data` do not affect an in-flight transfer.
- If `req` drops mid-transfer, the transfer still completes and `ack` still pulses.
- A channel whose `req` is still high in the IDLE cycle after its ACK is treated as a new request. That channel has the lowest priority at that point.
- In IDLE and ACK, `uart_data` holds its last value; only the new_data pulse matters.
- Reset has the same effect mid-transfer as at power-up. After reset:
  - state = IDLE, `last` = N-1, counter = 0;
  - `ack`, `uart_new_data`, `busy`, `grant_id`, and `uart_data` are all 0.
- A UART byte already started when reset hits is not tracked.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational paths from `req` or `data` to any output.
- Request sampled at the edge that ends IDLE cycle k:
  - First `uart_new_data` pulse in cycle k+1.
  - Without header: `ack` in cycle k+2+FRAME.
  - With header: `ack` in cycle k+3+2*FRAME.
- Back-to-back: the next IDLE evaluation is in the cycle after ACK. Minimum spacing between consecutive data-byte pulses is FRAME+3 cycles without the header.
- `uart_new_data` is never high in two consecutive cycles. Pulses are always at least FRAME+1 cycles apart.
- `busy` rises in the cycle after the winning IDLE cycle and falls in the cycle after ACK.

## Configuration
- `UART_TXARB_HEADER_EN` defined:
  - Each grant sends two bytes: header {4'hA, grant_id zero-extended to 4 bits}, then the data byte.
  - HDR/HWAIT states are present.
- Not defined:
  - HDR/HWAIT states are compiled out. IDLE goes directly to SEND.
  - Only the data byte is sent.

## Test plan
Bench parameters: CLOCK=1000, BAUD=100, N=4, GAP=4, giving FRAME=104.
- Single request, header off: `req`=4'b0010 with `data[1]`=8'h5C, sampled in IDLE cycle k.
  - `uart_new_data` pulses in cycle k+1 with `uart_data`=8'h5C.
  - `ack`=4'b0010 in cycle k+106.
  - `busy` is high from k+1 through k+106.
- Header on, same stimulus:
  - Pulse at k+1 with 8'hA1.
  - Pulse at k+106 with 8'h5C.
  - `ack` at k+211.
- All four requesting continuously from reset: grant order 0,1,2,3,0. Each `ack` is one-hot, one cycle wide.
- Fairness: channels 0 and 2 hold `req` high; channel 0 re-asserts immediately after its `ack`. Grants alternate 0,2,0,2.
- Request withdrawn: channel 3 drops `req` 10 cycles after its pulse. The frame completes, `ack[3]` still pulses, and no re-grant to channel 3 follows.
- Reset mid-frame: `rst`=0 for one cycle during DWAIT.
  - Next cycle: all outputs 0 and `busy`=0.
  - With `req`=4'b0100 held, the first grant after reset goes to channel 2 with a fresh FRAME wait.
